// File: rtl/carry_skip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : carry_skip_pkg
// Brief    : Shared slice width and sequencer state encoding for the
//            carry-skip wide-operand adder.
// Revision : 1.0 - initial release
// ============================================================================
package carry_skip_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/carry_skip_16bit.sv
`default_nettype none
// ============================================================================
// Module   : carry_skip_16bit
// Brief    : Combinational 16-bit carry-skip adder, four 4-bit ripple blocks
//            with a block-propagate bypass on each block's carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module carry_skip_16bit
    import carry_skip_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int C_BLK_W = 4;
    localparam int C_N_BLK = SLICE_W / C_BLK_W;

    logic w_c;
    logic w_c_blk_in;
    logic w_p_blk;
    logic w_p;
    int   w_i;

    always_comb begin
        sum        = '0;
        w_c        = cin;
        w_c_blk_in = cin;
        w_p_blk    = 1'b1;
        w_p        = 1'b0;
        w_i        = 0;
        for (int blk = 0; blk < C_N_BLK; blk++) begin
            w_c_blk_in = w_c;
            w_p_blk    = 1'b1;
            for (int k = 0; k < C_BLK_W; k++) begin
                w_i      = blk * C_BLK_W + k;
                w_p      = a[w_i] ^ b[w_i];
                sum[w_i] = w_p ^ w_c;
                w_p_blk  = w_p_blk & w_p;
                w_c      = (a[w_i] & b[w_i]) | (w_p & w_c);
            end
            // A fully-propagating block passes its incoming carry straight on
            if (w_p_blk) begin
                w_c = w_c_blk_in;
            end
        end
        cout = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/carry_skip_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : carry_skip_seq_adder
// Brief    : Multi-cycle WORDS*16-bit adder reusing one 16-bit carry-skip
//            slice per cycle, LS slice first. Optional subtract: CSA_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module carry_skip_seq_adder
    import carry_skip_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORDS*SLICE_W-1:0]   a,
    input  logic [WORDS*SLICE_W-1:0]   b,
    input  logic                       cin,
`ifdef CSA_SUB_EN
    input  logic                       sub,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDS*SLICE_W-1:0]   sum,
    output logic                       cout,
    output logic                       busy
);

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic             sub_q, sub_d;

    logic [SLICE_W-1:0] w_slice_a;
    logic [SLICE_W-1:0] w_slice_b;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic               w_sub_in;

`ifdef CSA_SUB_EN
    assign w_sub_in = sub;
`else
    assign w_sub_in = 1'b0;
`endif

    assign w_slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign w_slice_b = sub_q ? ~b_q[int'(idx_q)*SLICE_W +: SLICE_W]
                             :  b_q[int'(idx_q)*SLICE_W +: SLICE_W];

    carry_skip_16bit u_slice (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (carry_q),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        sub_d       = sub_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = w_sub_in;
                    // Two's-complement subtract: inverted B plus a forced carry-in
                    carry_d = w_sub_in ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = w_slice_sum;
                carry_d = w_slice_cout;
                if (idx_q == C_LAST_IDX) begin
                    cout_d      = w_slice_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sub_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            sub_q       <= sub_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_carry_skip_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_carry_skip_seq_adder
// Brief    : Directed, table-driven self-checking bench for
//            carry_skip_seq_adder (WORDS=4). Subtract vectors under CSA_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carry_skip_seq_adder;

    localparam int WORDS = 4;
    localparam int W     = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[9];

    carry_skip_seq_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    task automatic wait_valid(input string nm, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, " valid_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts,
                          input logic [W-1:0] es, input logic ec);
        int lat;
        wait_ready(nm);
        in_valid = 1'b1;
        a = ta; b = tb_; cin = tc; sub = ts;
        tick();
        in_valid = 1'b0;
        // operands disturbed after accept must not affect the result
        a = ~ta; b = ~tb_; cin = ~tc; sub = ~ts;
        wait_valid(nm, lat);
        chk({nm, " latency"}, 64'(lat), 64'(WORDS));
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, 64'(cout), 64'(ec));
        chk({nm, " busy"}, 64'(busy), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " valid_clear"}, 64'(out_valid), 64'd0);
        chk({nm, " idle_ready"}, 64'(in_ready), 64'd1);
        chk({nm, " sum_held"}, sum, es);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[2] = '{64'h000E, 64'h0001, 1'b1, 64'h0010, 1'b0};
        vecs[3] = '{64'd999, 64'h0, 1'b1, 64'd1000, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[5] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0};
        vecs[8] = '{64'h0000_0000_FFFF_FFF0, 64'h10, 1'b0, 64'h0000_0001_0000_0000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) tick();
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst sum", sum, 64'd0);
        chk("rst cout", 64'(cout), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst release in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                   vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Back-pressure in DONE; in_valid raised there must wait for IDLE
        wait_ready("bp");
        in_valid = 1'b1; a = 64'h100; b = 64'h23; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid("bp", lat);
        chk("bp sum", sum, 64'h123);
        in_valid = 1'b1; a = 64'd7; b = 64'd8; cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp hold%0d valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp hold%0d sum", k), sum, 64'h123);
            chk($sformatf("bp hold%0d cout", k), 64'(cout), 64'd0);
            chk($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release valid", 64'(out_valid), 64'd0);
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp next busy", 64'(busy), 64'd1);
        chk("bp next sum_kept", sum, 64'h123);
        wait_valid("bp next", lat);
        chk("bp next latency", 64'(lat), 64'(WORDS));
        chk("bp next sum", sum, 64'd15);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the second RUN cycle aborts the operation
        wait_ready("abort");
        in_valid = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h0; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort in_ready forced", 64'(in_ready), 64'd0);
        tick();
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort sum", sum, 64'd0);
        chk("abort cout", 64'(cout), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort no result", 64'(seen), 64'd0);
        run_op("post_abort", 64'd41, 64'd1, 1'b0, 1'b0, 64'd42, 1'b0);

`ifdef CSA_SUB_EN
        run_op("sub pos", 64'd999, 64'd5, 1'b0, 1'b1, 64'd994, 1'b1);
        run_op("sub neg", 64'd5, 64'd999, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FC1E, 1'b0);
        run_op("sub eq", 64'h1234_0000_0000_5678, 64'h1234_0000_0000_5678, 1'b1, 1'b1,
               64'h0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
